pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / stall controller for a 5-stage in-order core.
// Resolves memory waits, taken branches, load-use hazards, jumps and the
// halt drain sequence, and keeps a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_opcode,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic             ex_memRead,
  input  logic [3:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             dmem_req,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_JUMP = 4'b0111;

  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic            ret_drain, ret_drain_nxt;
  logic            mem_stall;
  logic            load_use;
  logic            cnt_en;

  // Counter never wraps: it sticks at all-ones once reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign mem_stall = mem_access && !dmem_ack;
  assign load_use  = ex_memRead && (ex_rd != 4'd0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // State, drain counter and return-to-drain flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      dcnt      <= '0;
      ret_drain <= 1'b0;
    end else begin
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      ret_drain <= ret_drain_nxt;
    end
  end

  // Next-state and control outputs; outputs forced low while reset is held.
  always_comb begin
    state_nxt     = state;
    dcnt_nxt      = dcnt;
    ret_drain_nxt = ret_drain;
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_hold    = 1'b0;
    dmem_req      = 1'b0;
    halted        = 1'b0;
    case (state)
      RUN: begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if (mem_stall) begin
          pc_write      = 1'b0;
          ifid_write    = 1'b0;
          exmem_hold    = 1'b1;
          dmem_req      = 1'b1;
          state_nxt     = MEMWAIT;
          ret_drain_nxt = 1'b0;
        end else begin
          dmem_req = mem_access;
          if (ex_branch_taken) begin
            // A halt or jump sitting in ID is on the wrong path and is squashed.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_opcode == OP_HALT) begin
            pc_write    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = DRAIN;
            dcnt_nxt    = DW'(DRAIN_CYCLES);
          end else if (id_opcode == OP_JUMP) begin
            ifid_flush = 1'b1;
          end
        end
      end
      MEMWAIT: begin
        dmem_req = 1'b1;
        if (!dmem_ack) begin
          exmem_hold = 1'b1;
        end else if (ret_drain) begin
          // Access done; resume the drain without consuming a drain cycle.
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_nxt   = DRAIN;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          state_nxt  = RUN;
        end
      end
      DRAIN: begin
        if (mem_stall) begin
          exmem_hold    = 1'b1;
          dmem_req      = 1'b1;
          state_nxt     = MEMWAIT;
          ret_drain_nxt = 1'b1;
        end else begin
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          dmem_req    = mem_access;
          dcnt_nxt    = dcnt - DW'(1);
          if (dcnt == DW'(1)) state_nxt = HALTED;
        end
      end
      HALTED: begin
        halted     = 1'b1;
        exmem_hold = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_hold  = 1'b0;
      dmem_req    = 1'b0;
      halted      = 1'b0;
    end
  end

  assign cnt_en = ((state == RUN) || (state == MEMWAIT)) && !ifid_write;

  // Stall-cycle performance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (cnt_en) stall_count <= sat_inc(stall_count);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed bench for pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 6;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       id_opcode = '0, id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             ex_memRead = 1'b0, ex_branch_taken = 1'b0;
  logic             mem_access = 1'b0, dmem_ack = 1'b0;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic             exmem_hold, dmem_req, halted;
  logic [CNT_W-1:0] stall_count;

  pipe_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
    .dmem_ack(dmem_ack), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_hold(exmem_hold), .dmem_req(dmem_req), .halted(halted),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // Model: mode 0 fetching, 1 waiting on memory, 2 draining, 3 stopped.
  int m_mode = 0;
  int m_left = 0;
  bit m_back = 0;   // waiting on memory interrupted a drain
  int m_stalls = 0;

  function automatic logic [6:0] dut_outs();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, dmem_req, halted};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_back = 0; m_stalls = 0;
  endtask

  // Expected controls for the current cycle plus the model's next values.
  task automatic ref_cycle(output logic [6:0] o, output int nmode, output int nleft,
                           output bit nback, output bit stall);
    bit pc, fw, fl, bb, hd, rq, h;
    bit ms, lu;
    ms = mem_access && !dmem_ack;
    lu = ex_memRead && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    {pc, fw, fl, bb, hd, rq, h} = '0;
    nmode = m_mode; nleft = m_left; nback = m_back;
    if (m_mode == 0) begin
      pc = 1; fw = 1;
      if (ms) begin
        pc = 0; fw = 0; hd = 1; rq = 1; nmode = 1; nback = 0;
      end else begin
        rq = mem_access;
        if (ex_branch_taken) begin fl = 1; bb = 1; end
        else if (lu) begin pc = 0; fw = 0; bb = 1; end
        else if (id_opcode == 4'hF) begin
          pc = 0; fl = 1; bb = 1; nmode = 2; nleft = DRAIN_CYCLES;
        end else if (id_opcode == 4'h7) fl = 1;
      end
    end else if (m_mode == 1) begin
      rq = 1;
      if (!dmem_ack) hd = 1;
      else if (m_back) begin fw = 1; fl = 1; bb = 1; nmode = 2; end
      else begin pc = 1; fw = 1; nmode = 0; end
    end else if (m_mode == 2) begin
      if (ms) begin hd = 1; rq = 1; nmode = 1; nback = 1; end
      else begin
        fw = 1; fl = 1; bb = 1; rq = mem_access;
        nleft = m_left - 1;
        if (m_left == 1) nmode = 3;
      end
    end else begin
      h = 1; hd = 1;
    end
    stall = (m_mode <= 1) && !fw;
    o = {pc, fw, fl, bb, hd, rq, h};
  endtask

  // One clock: compare at negedge, advance model at posedge, return at +1.
  task automatic step();
    logic [6:0] eo;
    int nm, nl;
    bit nb, st;
    @(negedge clk);
    ref_cycle(eo, nm, nl, nb, st);
    if (!rst_n) eo = '0;
    chk("controls", 32'(dut_outs()), 32'(eo));
    chk("stall_count", 32'(stall_count), 32'(m_stalls));
    @(posedge clk);
    if (rst_n) begin
      m_mode = nm; m_left = nl; m_back = nb;
      if (st && m_stalls < CNT_MAX) m_stalls++;
    end
    #1;
  endtask

  task automatic idle();
    id_opcode = 4'h0; id_rs1 = 4'h0; id_rs2 = 4'h0; ex_rd = 4'h0;
    ex_memRead = 0; ex_branch_taken = 0; mem_access = 0; dmem_ack = 0;
  endtask

  // Asynchronous reset pulse in the middle of a cycle; called at posedge+1.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_controls", 32'(dut_outs()), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    step();
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4) id_opcode = 4'hF;
    else if (r < 15) id_opcode = 4'h7;
    else begin
      id_opcode = 4'($urandom_range(0, 14));
      if (id_opcode == 4'h7) id_opcode = 4'h6;
    end
    id_rs1          = 4'($urandom_range(0, 3));
    id_rs2          = 4'($urandom_range(0, 3));
    ex_rd           = 4'($urandom_range(0, 3));
    ex_memRead      = ($urandom_range(0, 99) < 35);
    ex_branch_taken = ($urandom_range(0, 99) < 15);
    mem_access      = ($urandom_range(0, 99) < 30);
    dmem_ack        = ($urandom_range(0, 99) < 50);
  endtask

  initial begin
    idle();
    #1;
    chk("reset_controls", 32'(dut_outs()), 32'd0);
    chk("reset_stall_count", 32'(stall_count), 32'd0);
    step();
    #2 rst_n = 1'b1;
    #1;

    // First edge after release fetches normally.
    step();
    chk("first_fetch_state_run", 32'(halted), 32'd0);

    // Load-use on rs2, then the same pattern with ex_rd = 0.
    ex_memRead = 1; ex_rd = 4'd3; id_rs2 = 4'd3;
    step();
    chk("load_use_count", 32'(stall_count), 32'd1);
    idle();
    step();
    ex_memRead = 1; ex_rd = 4'd0; id_rs2 = 4'd0;
    step();
    chk("load_use_rd0_count", 32'(stall_count), 32'd1);
    idle();

    // Memory wait: ack low four cycles, then high.
    async_reset();
    mem_access = 1; dmem_ack = 0;
    repeat (4) step();
    dmem_ack = 1;
    step();
    chk("memwait_stall_count", 32'(stall_count), 32'd4);
    idle();
    step();
    chk("memwait_back_to_fetch", 32'(pc_write), 32'd1);

    // Taken branch squashes a halt in ID.
    ex_branch_taken = 1; id_opcode = 4'hF;
    step();
    idle();
    repeat (6) step();
    chk("branch_squash_halt", 32'(halted), 32'd0);

    // Halt drain, no memory stalls: halted after exactly four edges.
    id_opcode = 4'hF;
    step();
    idle();
    step(); step();
    chk("halt_edge3", 32'(halted), 32'd0);
    step();
    chk("halt_edge4", 32'(halted), 32'd1);
    step();

    // Async reset while halted.
    async_reset();
    step();
    chk("post_halt_fetch", 32'(pc_write), 32'd1);

    // Halt drain with a two-cycle memory access: halted after six edges.
    id_opcode = 4'hF;
    step();
    idle();
    step();
    mem_access = 1; dmem_ack = 0;
    step();
    dmem_ack = 1;
    step();
    idle();
    step();
    chk("halt_stall_edge5", 32'(halted), 32'd0);
    step();
    chk("halt_stall_edge6", 32'(halted), 32'd1);

    // Counter saturation.
    async_reset();
    mem_access = 1; dmem_ack = 0;
    repeat ((1 << CNT_W) + 3) step();
    chk("saturation", 32'(stall_count), 32'(CNT_MAX));
    idle();

    // Randomized traffic with occasional asynchronous resets.
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if ($urandom_range(0, 99) < 2) async_reset();
      else step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
